// File: rtl/controle_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM states, instruction classes, opcode/funct values and ula32 selector codes.
package controle_pkg;

  typedef enum logic [3:0] {
    EST_RESET     = 4'd0,
    EST_FETCH     = 4'd1,
    EST_DECODE    = 4'd2,
    EST_EXEC_R    = 4'd3,
    EST_WB_R      = 4'd4,
    EST_EXEC_I    = 4'd5,
    EST_WB_I      = 4'd6,
    EST_MEM_ADDR  = 4'd7,
    EST_MEM_READ  = 4'd8,
    EST_WB_LOAD   = 4'd9,
    EST_MEM_WRITE = 4'd10,
    EST_BRANCH    = 4'd11,
    EST_JUMP      = 4'd12
  } estado_t;

  typedef enum logic [2:0] {
    CL_R_ADD  = 3'd0,
    CL_R_SUB  = 3'd1,
    CL_R_AND  = 3'd2,
    CL_ADDI   = 3'd3,
    CL_LW     = 3'd4,
    CL_SW     = 3'd5,
    CL_BRANCH = 3'd6,
    CL_JUMP   = 3'd7
  } classe_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ULA_LOAD = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;
  localparam logic [2:0] ULA_INC  = 3'b100;
  localparam logic [2:0] ULA_NOT  = 3'b101;
  localparam logic [2:0] ULA_XOR  = 3'b110;
  localparam logic [2:0] ULA_CMP  = 3'b111;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_QUATRO = 2'b01;
  localparam logic [1:0] SRC_B_EXT    = 2'b10;
  localparam logic [1:0] SRC_B_EXT_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ULA    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic [2:0] ula_op_r(input classe_t classe);
    case (classe)
      CL_R_SUB: ula_op_r = ULA_SUB;
      CL_R_AND: ula_op_r = ULA_AND;
      default:  ula_op_r = ULA_ADD;
    endcase
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control bundle between the multicycle control unit (master) and the datapath (slave).
interface controle_multiciclo_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ula_overflow;
  logic       mem_wr;
  logic       i_or_d;
  logic       ir_write;
  logic       load_mdr;
  logic       load_a;
  logic       load_b;
  logic       load_aluout;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       ula_src_a;
  logic [1:0] ula_src_b;
  logic [2:0] ula_op;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic [1:0] pc_source;
  logic       instr_invalida;
  logic       excecao_overflow;
  logic [3:0] estado;

  modport master (
    input  opcode, funct, ula_overflow,
    output mem_wr, i_or_d, ir_write, load_mdr, load_a, load_b, load_aluout,
           reg_write, reg_dst, mem_to_reg, ula_src_a, ula_src_b, ula_op,
           pc_write, pc_write_cond, branch_ne, pc_source,
           instr_invalida, excecao_overflow, estado
  );

  modport slave (
    output opcode, funct, ula_overflow,
    input  mem_wr, i_or_d, ir_write, load_mdr, load_a, load_b, load_aluout,
           reg_write, reg_dst, mem_to_reg, ula_src_a, ula_src_b, ula_op,
           pc_write, pc_write_cond, branch_ne, pc_source,
           instr_invalida, excecao_overflow, estado
  );
endinterface

// File: rtl/controle_decod.sv
// Combinational opcode/funct classifier: maps an instruction to its class and
// flags anything the control unit does not implement.
module controle_decod
  import controle_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output classe_t    classe,
  output logic       valida
);

  // Instruction class lookup; unsupported encodings leave valida low.
  always_comb begin
    classe = CL_JUMP;
    valida = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADD: begin classe = CL_R_ADD; valida = 1'b1; end
          FN_SUB: begin classe = CL_R_SUB; valida = 1'b1; end
          FN_AND: begin classe = CL_R_AND; valida = 1'b1; end
          default: begin classe = CL_R_ADD; valida = 1'b0; end
        endcase
      end
      OP_ADDI:        begin classe = CL_ADDI;   valida = 1'b1; end
      OP_LW:          begin classe = CL_LW;     valida = 1'b1; end
      OP_SW:          begin classe = CL_SW;     valida = 1'b1; end
      OP_BEQ, OP_BNE: begin classe = CL_BRANCH; valida = 1'b1; end
      OP_J:           begin classe = CL_JUMP;   valida = 1'b1; end
      default:        begin classe = CL_JUMP;   valida = 1'b0; end
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/
// writeback, with MEM_WAIT extra cycles on every memory read.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input logic                  clk,
  input logic                  reset,
  controle_multiciclo_if.master bus
);

  localparam logic [2:0] ULTIMO_CNT = 3'(MEM_WAIT);

  estado_t    estado_r;
  estado_t    estado_nx_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nx_s;
  logic       inval_r;
  logic       inval_nx_s;
  logic       ovf_r;
  logic       ovf_nx_s;
  logic       ultimo_s;
  classe_t    classe_s;
  logic       valida_s;

  controle_decod u_decod (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .classe (classe_s),
    .valida (valida_s)
  );

  assign ultimo_s = (cnt_r == ULTIMO_CNT);

  // State, wait counter and exception pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_r <= EST_RESET;
      cnt_r    <= 3'd0;
      inval_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      estado_r <= estado_nx_s;
      cnt_r    <= cnt_nx_s;
      inval_r  <= inval_nx_s;
      ovf_r    <= ovf_nx_s;
    end
  end

  // Next-state selection and exception detection on the outgoing transition.
  always_comb begin
    estado_nx_s = EST_RESET;
    inval_nx_s  = 1'b0;
    ovf_nx_s    = 1'b0;
    case (estado_r)
      EST_RESET: estado_nx_s = EST_FETCH;
      EST_FETCH: begin
        if (ultimo_s) estado_nx_s = EST_DECODE;
        else          estado_nx_s = EST_FETCH;
      end
      EST_DECODE: begin
        if (!valida_s) begin
          estado_nx_s = EST_FETCH;
          inval_nx_s  = 1'b1;
        end else begin
          case (classe_s)
            CL_R_ADD, CL_R_SUB, CL_R_AND: estado_nx_s = EST_EXEC_R;
            CL_ADDI:                      estado_nx_s = EST_EXEC_I;
            CL_LW, CL_SW:                 estado_nx_s = EST_MEM_ADDR;
            CL_BRANCH:                    estado_nx_s = EST_BRANCH;
            CL_JUMP:                      estado_nx_s = EST_JUMP;
            default:                      estado_nx_s = EST_FETCH;
          endcase
        end
      end
      // AND cannot overflow, so its flag is ignored.
      EST_EXEC_R: begin
        if (bus.ula_overflow && (classe_s != CL_R_AND)) begin
          estado_nx_s = EST_FETCH;
          ovf_nx_s    = 1'b1;
        end else begin
          estado_nx_s = EST_WB_R;
        end
      end
      EST_EXEC_I: begin
        if (bus.ula_overflow) begin
          estado_nx_s = EST_FETCH;
          ovf_nx_s    = 1'b1;
        end else begin
          estado_nx_s = EST_WB_I;
        end
      end
      EST_MEM_ADDR: begin
        if (classe_s == CL_SW) estado_nx_s = EST_MEM_WRITE;
        else                   estado_nx_s = EST_MEM_READ;
      end
      EST_MEM_READ: begin
        if (ultimo_s) estado_nx_s = EST_WB_LOAD;
        else          estado_nx_s = EST_MEM_READ;
      end
      EST_WB_R, EST_WB_I, EST_WB_LOAD, EST_MEM_WRITE, EST_BRANCH, EST_JUMP:
        estado_nx_s = EST_FETCH;
      default: estado_nx_s = EST_RESET;
    endcase
  end

  // Wait counter restarts whenever a different state is entered.
  always_comb begin
    cnt_nx_s = 3'd0;
    if (estado_nx_s == estado_r) cnt_nx_s = cnt_r + 3'd1;
    else                         cnt_nx_s = 3'd0;
  end

  // Moore output decode from state and wait counter.
  always_comb begin
    bus.mem_wr        = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.load_mdr      = 1'b0;
    bus.load_a        = 1'b0;
    bus.load_b        = 1'b0;
    bus.load_aluout   = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ula_src_a     = 1'b0;
    bus.ula_src_b     = SRC_B_REG;
    bus.ula_op        = ULA_LOAD;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ne     = 1'b0;
    bus.pc_source     = PC_SRC_ULA;
    case (estado_r)
      EST_FETCH: begin
        if (ultimo_s) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.ula_src_b = SRC_B_QUATRO;
          bus.ula_op    = ULA_ADD;
        end else begin
          bus.ir_write  = 1'b0;
        end
      end
      EST_DECODE: begin
        bus.load_a      = 1'b1;
        bus.load_b      = 1'b1;
        bus.ula_src_b   = SRC_B_EXT_SH;
        bus.ula_op      = ULA_ADD;
        bus.load_aluout = 1'b1;
      end
      EST_EXEC_R: begin
        bus.ula_src_a   = 1'b1;
        bus.ula_op      = ula_op_r(classe_s);
        bus.load_aluout = 1'b1;
      end
      EST_WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      EST_EXEC_I, EST_MEM_ADDR: begin
        bus.ula_src_a   = 1'b1;
        bus.ula_src_b   = SRC_B_EXT;
        bus.ula_op      = ULA_ADD;
        bus.load_aluout = 1'b1;
      end
      EST_WB_I: bus.reg_write = 1'b1;
      EST_MEM_READ: begin
        bus.i_or_d = 1'b1;
        if (ultimo_s) bus.load_mdr = 1'b1;
        else          bus.load_mdr = 1'b0;
      end
      EST_WB_LOAD: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      EST_MEM_WRITE: begin
        bus.i_or_d = 1'b1;
        bus.mem_wr = 1'b1;
      end
      EST_BRANCH: begin
        bus.ula_src_a     = 1'b1;
        bus.ula_op        = ULA_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PC_SRC_ALUOUT;
        bus.branch_ne     = (bus.opcode == OP_BNE);
      end
      EST_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = PC_SRC_JUMP;
      end
      default: bus.mem_wr = 1'b0;
    endcase
  end

  assign bus.instr_invalida   = inval_r;
  assign bus.excecao_overflow = ovf_r;
  assign bus.estado           = estado_r;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: two instances (MEM_WAIT=1 and 2), an instruction-level
// trace model, a table of per-instruction expectations and randomized instruction streams.
module tb_controle_multiciclo;
  import controle_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controle_multiciclo_if b0 ();
  controle_multiciclo_if b1 ();

  controle_multiciclo #(.MEM_WAIT(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  controle_multiciclo #(.MEM_WAIT(2)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  typedef struct packed {
    logic       mem_wr, i_or_d, ir_write, load_mdr, load_a, load_b, load_aluout;
    logic       reg_write, reg_dst, mem_to_reg, ula_src_a;
    logic [1:0] ula_src_b;
    logic [2:0] ula_op;
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       instr_invalida, excecao_overflow;
    logic [3:0] estado;
  } ctl_t;

  ctl_t obs0, obs1;
  assign obs0 = {b0.mem_wr, b0.i_or_d, b0.ir_write, b0.load_mdr, b0.load_a, b0.load_b,
                 b0.load_aluout, b0.reg_write, b0.reg_dst, b0.mem_to_reg, b0.ula_src_a,
                 b0.ula_src_b, b0.ula_op, b0.pc_write, b0.pc_write_cond, b0.branch_ne,
                 b0.pc_source, b0.instr_invalida, b0.excecao_overflow, b0.estado};
  assign obs1 = {b1.mem_wr, b1.i_or_d, b1.ir_write, b1.load_mdr, b1.load_a, b1.load_b,
                 b1.load_aluout, b1.reg_write, b1.reg_dst, b1.mem_to_reg, b1.ula_src_a,
                 b1.ula_src_b, b1.ula_op, b1.pc_write, b1.pc_write_cond, b1.branch_ne,
                 b1.pc_source, b1.instr_invalida, b1.excecao_overflow, b1.estado};

  typedef struct {
    int         sel;
    logic [5:0] op;
    logic [5:0] fn;
    logic       ovf;
    int         ciclos;
    logic       efeito;
    logic       inv;
    logic       xov;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  ctl_t exp_q[$];
  logic pend_inv, pend_ovf;
  vec_t tabela[12];
  logic [5:0] ops[10];

  function automatic ctl_t obs(input int sel);
    if (sel == 1) return obs1;
    else          return obs0;
  endfunction

  function automatic int wait_of(input int sel);
    if (sel == 1) return 2;
    else          return 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    b0.opcode = op; b0.funct = fn; b0.ula_overflow = ovf;
    b1.opcode = op; b1.funct = fn; b1.ula_overflow = ovf;
  endtask

  // Leaves both DUTs in their first FETCH cycle, sampled 1 time unit after the edge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_w1", 32'(obs0), 32'd0);
    chk("reset_hold_w2", 32'(obs1), 32'd0);
    reset = 1'b0;
    chk("reset_state_w1", 32'(obs0), 32'd0);
    chk("reset_state_w2", 32'(obs1), 32'd0);
    @(posedge clk);
    #1;
    chk("first_fetch", 32'({obs0.estado, obs1.estado}), 32'({EST_FETCH, EST_FETCH}));
    pend_inv = 1'b0;
    pend_ovf = 1'b0;
  endtask

  // Expected per-cycle trace of one instruction, starting at its first FETCH cycle.
  task automatic gen_instr(input int w, input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    ctl_t c;
    for (int i = 0; i <= w; i++) begin
      c = '0;
      c.estado = EST_FETCH;
      if (i == 0) begin
        c.instr_invalida   = pend_inv;
        c.excecao_overflow = pend_ovf;
      end
      if (i == w) begin
        c.ir_write = 1'b1; c.pc_write = 1'b1; c.ula_src_b = 2'b01; c.ula_op = 3'b001;
      end
      exp_q.push_back(c);
    end
    pend_inv = 1'b0;
    pend_ovf = 1'b0;
    c = '0;
    c.estado = EST_DECODE;
    c.load_a = 1'b1; c.load_b = 1'b1; c.ula_src_b = 2'b11; c.ula_op = 3'b001; c.load_aluout = 1'b1;
    exp_q.push_back(c);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      c = '0;
      c.estado = EST_EXEC_R;
      c.ula_src_a = 1'b1; c.load_aluout = 1'b1;
      c.ula_op = (fn == 6'h20) ? 3'b001 : ((fn == 6'h22) ? 3'b010 : 3'b011);
      exp_q.push_back(c);
      if (ovf && fn != 6'h24) begin
        pend_ovf = 1'b1;
      end else begin
        c = '0; c.estado = EST_WB_R; c.reg_write = 1'b1; c.reg_dst = 1'b1;
        exp_q.push_back(c);
      end
    end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
      c = '0;
      c.estado = (op == 6'h08) ? EST_EXEC_I : EST_MEM_ADDR;
      c.ula_src_a = 1'b1; c.ula_src_b = 2'b10; c.ula_op = 3'b001; c.load_aluout = 1'b1;
      exp_q.push_back(c);
      if (op == 6'h08) begin
        if (ovf) begin
          pend_ovf = 1'b1;
        end else begin
          c = '0; c.estado = EST_WB_I; c.reg_write = 1'b1;
          exp_q.push_back(c);
        end
      end else if (op == 6'h23) begin
        for (int i = 0; i <= w; i++) begin
          c = '0; c.estado = EST_MEM_READ; c.i_or_d = 1'b1; c.load_mdr = (i == w);
          exp_q.push_back(c);
        end
        c = '0; c.estado = EST_WB_LOAD; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
        exp_q.push_back(c);
      end else begin
        c = '0; c.estado = EST_MEM_WRITE; c.i_or_d = 1'b1; c.mem_wr = 1'b1;
        exp_q.push_back(c);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c = '0;
      c.estado = EST_BRANCH;
      c.ula_src_a = 1'b1; c.ula_op = 3'b010; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      c.branch_ne = (op == 6'h05);
      exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = '0; c.estado = EST_JUMP; c.pc_write = 1'b1; c.pc_source = 2'b10;
      exp_q.push_back(c);
    end else begin
      pend_inv = 1'b1;
    end
  endtask

  // Opcode/funct change only in the last FETCH cycle, as the instruction register would.
  task automatic run_model(input int sel, input logic [5:0] op, input logic [5:0] fn,
                           input logic ovf, input string nm);
    ctl_t e;
    int   k;
    gen_instr(wait_of(sel), op, fn, ovf);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.ir_write) set_in(op, fn, ovf);
      chk($sformatf("%s_c%0d", nm, k), 32'(obs(sel)), 32'(e));
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_next(input int sel, input string nm);
    ctl_t o;
    o = obs(sel);
    chk(nm, 32'({o.estado, o.instr_invalida, o.excecao_overflow}),
        32'({EST_FETCH, pend_inv, pend_ovf}));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic seen, efeito, done;
    ctl_t o;
    set_in(v.op, v.fn, v.ovf);
    n = 1; seen = 1'b0; efeito = 1'b0; done = 1'b0;
    for (int g = 0; g < 64 && !done; g++) begin
      @(posedge clk);
      #1;
      o = obs(v.sel);
      if (o.estado == EST_FETCH && seen) begin
        done = 1'b1;
      end else begin
        if (o.estado != EST_FETCH) seen = 1'b1;
        efeito = efeito | o.reg_write | o.mem_wr | o.pc_write_cond;
        n++;
      end
    end
    chk($sformatf("vec%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("vec%0d_ciclos", idx), 32'(n), 32'(v.ciclos));
    chk($sformatf("vec%0d_efeito", idx), 32'(efeito), 32'(v.efeito));
    chk($sformatf("vec%0d_flags", idx), 32'({o.instr_invalida, o.excecao_overflow}),
        32'({v.inv, v.xov}));
    @(posedge clk);
    #1;
    o = obs(v.sel);
    chk($sformatf("vec%0d_pulse_end", idx), 32'({o.instr_invalida, o.excecao_overflow}), 32'd0);
  endtask

  initial begin
    set_in(6'h00, 6'h00, 1'b0);
    pend_inv = 1'b0;
    pend_ovf = 1'b0;

    //            sel op     fn     ovf  ciclos efeito inv  xov
    tabela[0]  = '{0, 6'h00, 6'h20, 1'b0, 5, 1'b1, 1'b0, 1'b0};
    tabela[1]  = '{0, 6'h00, 6'h22, 1'b1, 4, 1'b0, 1'b0, 1'b1};
    tabela[2]  = '{0, 6'h00, 6'h24, 1'b1, 5, 1'b1, 1'b0, 1'b0};
    tabela[3]  = '{0, 6'h08, 6'h00, 1'b1, 4, 1'b0, 1'b0, 1'b1};
    tabela[4]  = '{1, 6'h08, 6'h15, 1'b0, 6, 1'b1, 1'b0, 1'b0};
    tabela[5]  = '{1, 6'h23, 6'h00, 1'b1, 9, 1'b1, 1'b0, 1'b0};
    tabela[6]  = '{0, 6'h2B, 6'h00, 1'b0, 5, 1'b1, 1'b0, 1'b0};
    tabela[7]  = '{0, 6'h04, 6'h00, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    tabela[8]  = '{1, 6'h05, 6'h00, 1'b0, 5, 1'b1, 1'b0, 1'b0};
    tabela[9]  = '{0, 6'h02, 6'h00, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    tabela[10] = '{0, 6'h3F, 6'h00, 1'b0, 3, 1'b0, 1'b1, 1'b0};
    tabela[11] = '{1, 6'h00, 6'h08, 1'b0, 4, 1'b0, 1'b1, 1'b0};

    ops = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h11};

    for (int i = 0; i < 12; i++) begin
      do_reset();
      run_vec(tabela[i], i);
    end

    // Cycle-exact traces for the scenarios the datapath depends on.
    do_reset();
    run_model(0, 6'h00, 6'h20, 1'b0, "radd_w1");
    run_model(0, 6'h04, 6'h00, 1'b0, "beq_w1");
    run_model(0, 6'h05, 6'h00, 1'b1, "bne_w1");
    run_model(0, 6'h08, 6'h00, 1'b1, "addi_ovf_w1");
    run_model(0, 6'h3F, 6'h00, 1'b0, "inval_w1");
    check_next(0, "seq_w1_end");
    do_reset();
    run_model(1, 6'h23, 6'h00, 1'b0, "lw_w2");
    check_next(1, "seq_w2_end");

    // Reset asserted in the last MEM_READ cycle drops every strobe at once.
    do_reset();
    set_in(6'h23, 6'h00, 1'b0);
    for (int g = 0; g < 20 && !obs1.load_mdr; g++) begin
      @(posedge clk);
      #1;
    end
    chk("lw_mdr_reached", 32'({obs1.estado, obs1.load_mdr}), 32'({EST_MEM_READ, 1'b1}));
    #2 reset = 1'b1;
    #1 chk("async_drop", 32'(obs1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_reset_state", 32'(obs1.estado), 32'(EST_RESET));
    @(posedge clk);
    #1;
    chk("post_reset_fetch", 32'(obs1.estado), 32'(EST_FETCH));

    // Random instruction streams against the trace model, on each instance.
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      for (int n = 0; n < 40; n++) begin
        logic [5:0] op, fn;
        logic       ovf;
        op = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
        else if ($urandom_range(0, 2) == 0) fn = 6'h20;
        else if ($urandom_range(0, 1) == 0) fn = 6'h22;
        else fn = 6'h24;
        ovf = 1'($urandom_range(0, 1));
        run_model(sel, op, fn, ovf, $sformatf("rnd%0d_%0d", sel, n));
      end
      check_next(sel, $sformatf("rnd%0d_end", sel));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
